// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux: walks enabled channels in ascending order,
// settles each select for DWELL cycles, samples f and hands it off via valid/ready.
module mux4_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] en_mask,
  output logic [1:0] s,
  input  logic       f,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       sample_bit,
  output logic [1:0] sample_ch,
  output logic [3:0] frame,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [3:0]       mask_q;
  logic [1:0]       ch_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] first_ch, next_ch;
  logic       first_found, has_next;
  logic       load_first, load_next, capture, handshake, clr_frame;

  // Lowest set bit of the incoming mask and next set bit above the current channel.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    has_next    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (en_mask[i] && !first_found) begin
        first_ch    = 2'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && (i > 32'(ch_q)) && !has_next) begin
        next_ch  = 2'(i);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    clr_frame  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr_frame = 1'b1;
          if (first_found) begin
            load_first = 1'b1;
            state_nxt  = SETTLE;
          end else begin
            state_nxt  = DONE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (sample_ready) begin
          handshake = 1'b1;
          if (has_next) begin
            load_next = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= '0;
      ch_q         <= '0;
      cnt_q        <= '0;
      s            <= '0;
      sample_valid <= 1'b0;
      sample_bit   <= 1'b0;
      sample_ch    <= '0;
      frame        <= '0;
    end else begin
      if (state == SETTLE) cnt_q <= cnt_q + 1'b1;
      if (clr_frame) frame <= '0;
      if (load_first) begin
        mask_q <= en_mask;
        ch_q   <= first_ch;
        s      <= first_ch;
        cnt_q  <= '0;
      end
      if (capture) begin
        sample_bit   <= f;
        sample_ch    <= ch_q;
        frame[ch_q]  <= f;
        sample_valid <= 1'b1;
      end
      if (handshake) sample_valid <= 1'b0;
      if (load_next) begin
        ch_q  <= next_ch;
        s     <= next_ch;
        cnt_q <= '0;
      end
    end
  end

  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
